// File: rtl/csd_seq_ctrl.sv
//----------------------------------------------------------------------------
// Module   : csd_seq_ctrl
// Purpose  : Sequencing FSM for the CSD-pattern datapath. Scans the CSD
//            memory for +1 digits, stores the first K_COUNT hit indices in
//            K memory, reloads them into the K registers, fetches the CSD
//            digits they address and latches the datapath result flags.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module csd_seq_ctrl #(
  parameter logic [3:0]  SCAN_LAST = 4'd15,
  parameter int unsigned K_COUNT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       Zcsd,
  input  logic       Zcnt,
  input  logic       Zk,
  input  logic       ZCsdK,
  output logic       start,
  output logic       weCsd,
  output logic       reCsd,
  output logic       weK,
  output logic       reK,
  output logic       Load,
  output logic       enable,
  output logic       loadCnt,
  output logic       enCnt,
  output logic [3:0] sel_i,
  output logic       kSel,
  output logic       selSaveK,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       kGap,
  output logic       csdSym
);

  localparam logic [3:0] SEL_LAST = 4'(K_COUNT);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    S_RD  = 4'd2,
    S_CHK = 4'd3,
    S_INC = 4'd4,
    S_WR  = 4'd5,
    K_CLR = 4'd6,
    K_INC = 4'd7,
    K_RD  = 4'd8,
    K_CAP = 4'd9,
    F_RD  = 4'd10,
    F_CAP = 4'd11,
    EVAL  = 4'd12,
    DONE  = 4'd13
  } state_t;

  state_t     state_q;
  logic [3:0] s_q;
  logic [3:0] sel_q;
  logic       found_q;
  logic       kgap_q;
  logic       csdsym_q;

  // A scan step may advance only while the scan index has not reached the end
  logic       scan_more;
  assign scan_more = (s_q != SCAN_LAST);

  // State walk, scan index, fetch address select and latched results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= 4'd0;
      sel_q    <= 4'd0;
      found_q  <= 1'b0;
      kgap_q   <= 1'b0;
      csdsym_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (go) state_q <= INIT;
        INIT: begin
          s_q     <= 4'd0;
          sel_q   <= 4'd0;
          state_q <= S_RD;
        end
        S_RD:  state_q <= S_CHK;
        S_CHK: begin
          if (Zcsd) begin
            state_q <= S_INC;
          end else if (scan_more) begin
            s_q     <= s_q + 4'd1;
            state_q <= S_RD;
          end else begin
            // Scan exhausted without enough hits: report a clean failure
            found_q  <= 1'b0;
            kgap_q   <= 1'b0;
            csdsym_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        S_INC: state_q <= S_WR;
        S_WR: begin
          // A full hit count wins even on the last scanned address
          if (Zcnt) begin
            state_q <= K_CLR;
          end else if (scan_more) begin
            s_q     <= s_q + 4'd1;
            state_q <= S_RD;
          end else begin
            found_q  <= 1'b0;
            kgap_q   <= 1'b0;
            csdsym_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        K_CLR: state_q <= K_INC;
        K_INC: state_q <= K_RD;
        K_RD:  state_q <= K_CAP;
        K_CAP: begin
          if (Zcnt) begin
            sel_q   <= 4'd1;
            state_q <= F_RD;
          end else begin
            state_q <= K_INC;
          end
        end
        F_RD:  state_q <= F_CAP;
        F_CAP: begin
          if (sel_q == SEL_LAST) begin
            sel_q   <= 4'd0;
            state_q <= EVAL;
          end else begin
            sel_q   <= sel_q + 4'd1;
            state_q <= F_RD;
          end
        end
        EVAL: begin
          kgap_q   <= Zk;
          csdsym_q <= ZCsdK;
          found_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath strobes decoded from the state register; enable also looks at the scan outcome
  always_comb begin
    reCsd   = 1'b0;
    weK     = 1'b0;
    reK     = 1'b0;
    Load    = 1'b0;
    enable  = 1'b0;
    loadCnt = 1'b0;
    enCnt   = 1'b0;
    case (state_q)
      INIT: begin
        Load    = 1'b1;
        loadCnt = 1'b1;
      end
      S_RD:  reCsd = 1'b1;
      S_CHK: enable = ~Zcsd & scan_more;
      S_INC: enCnt = 1'b1;
      S_WR: begin
        weK    = 1'b1;
        enable = ~Zcnt & scan_more;
      end
      K_CLR: loadCnt = 1'b1;
      K_INC: enCnt = 1'b1;
      K_RD:  reK = 1'b1;
      F_RD:  reCsd = 1'b1;
      default: ;
    endcase
  end

  assign start    = (state_q != IDLE) && (state_q != DONE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign weCsd    = 1'b0;
  assign kSel     = 1'b0;
  assign selSaveK = 1'b0;
  assign sel_i    = sel_q;
  assign found    = found_q;
  assign kGap     = kgap_q;
  assign csdSym   = csdsym_q;

endmodule

`default_nettype wire

// File: tb/tb_csd_seq_ctrl.sv
//----------------------------------------------------------------------------
// Module   : tb_csd_seq_ctrl
// Purpose  : Self-checking bench for csd_seq_ctrl with a behavioural
//            datapath model (memories, counters, K/CSD registers, flags).
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_csd_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       Zcsd, Zcnt, Zk, ZCsdK;
  logic       start, weCsd, reCsd, weK, reK, Load, enable, loadCnt, enCnt;
  logic [3:0] sel_i;
  logic       kSel, selSaveK, busy, done, found, kGap, csdSym;

  csd_seq_ctrl #(.SCAN_LAST(4'd15), .K_COUNT(4)) dut (
    .clk(clk), .reset(reset), .go(go),
    .Zcsd(Zcsd), .Zcnt(Zcnt), .Zk(Zk), .ZCsdK(ZCsdK),
    .start(start), .weCsd(weCsd), .reCsd(reCsd), .weK(weK), .reK(reK),
    .Load(Load), .enable(enable), .loadCnt(loadCnt), .enCnt(enCnt),
    .sel_i(sel_i), .kSel(kSel), .selSaveK(selSaveK),
    .busy(busy), .done(done), .found(found), .kGap(kGap), .csdSym(csdSym)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural datapath ----------------
  logic signed [1:0] csd_mem [16];
  logic        [3:0] kmem    [4];
  logic        [3:0] regK    [4];
  logic signed [1:0] regCsd  [4];
  logic        [3:0] i_q;
  logic        [2:0] cnti_q;
  logic signed [1:0] csd_rd;
  logic        [3:0] k_rd;
  logic              rek_d, recsd_d;
  logic              kclr = 1'b0;
  logic        [1:0] kidx, sidx;
  logic        [3:0] addr;

  assign kidx = cnti_q[1:0] - 2'd1;
  assign sidx = sel_i[1:0] - 2'd1;
  assign addr = (sel_i == 4'd0) ? i_q : regK[sidx];

  function automatic logic gap_ok(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, b} > ({1'b0, a} + 5'd1);
  endfunction

  assign Zcsd  = (csd_rd == 2'sd1);
  assign Zcnt  = (cnti_q == 3'd4);
  assign Zk    = Zcnt && gap_ok(regK[0], regK[1]) && gap_ok(regK[1], regK[2])
                      && gap_ok(regK[2], regK[3]);
  assign ZCsdK = (regCsd[0] == 2'sd1) && (regCsd[1] == 2'sd1)
              && (regCsd[2] == 2'sd1) && (regCsd[3] == 2'sd1);

  always @(posedge clk) begin
    if (kclr) begin
      for (int k = 0; k < 4; k++) kmem[k] <= 4'd0;
    end
    if (reset) begin
      i_q <= 4'd0; cnti_q <= 3'd0; csd_rd <= 2'sd0; k_rd <= 4'd0;
      rek_d <= 1'b0; recsd_d <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        regK[k] <= 4'd0; regCsd[k] <= 2'sd0;
      end
    end else begin
      if (Load) i_q <= 4'd0; else if (enable) i_q <= i_q + 4'd1;
      if (loadCnt) cnti_q <= 3'd0; else if (enCnt) cnti_q <= cnti_q + 3'd1;
      if (reCsd) csd_rd <= csd_mem[addr];
      if (reK) k_rd <= kmem[kidx];
      if (weK) kmem[kidx] <= i_q;
      rek_d   <= reK;
      recsd_d <= reCsd && (sel_i != 4'd0);
      if (rek_d) regK[kidx] <= k_rd;
      if (recsd_d) regCsd[sidx] <= csd_rd;
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    int   lat;
    logic f;
    logic kg;
    logic cs;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] all_outs();
    return {start, weCsd, reCsd, weK, reK, Load, enable, loadCnt, enCnt,
            sel_i, kSel, selSaveK, busy, done, found, kGap, csdSym};
  endfunction

  task automatic load_csd(input logic [15:0] ones);
    for (int a = 0; a < 16; a++) csd_mem[a] = ones[a] ? 2'sd1 : 2'sd0;
    kclr = 1'b1;
    @(posedge clk); #1;
    kclr = 1'b0;
  endtask

  // One run: push expectation, pulse go, follow the DUT to done and compare
  task automatic do_run(input string tag, input logic [15:0] ones, input exp_t e,
                        input logic [15:0] exp_k, input logic exp_wek, input logic poke);
    int   n;
    int   dones;
    logic wek_seen;
    exp_t got;
    load_csd(ones);
    sb.push_back(e);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    n = 0; wek_seen = 1'b0; dones = 0;
    while (!done && n < 200) begin
      if (weK) wek_seen = 1'b1;
      if (n == 2) check({tag, "_start_run"}, start, 1'b1);
      if (poke && n == 10) go = 1'b1;
      if (poke && n == 11) go = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 32'(n), 32'd200 + 32'd1);
    end else begin
      dones++;
      got = sb.pop_front();
      check({tag, "_latency"}, 32'(n), 32'(got.lat));
      check({tag, "_found"}, found, got.f);
      check({tag, "_kGap"}, kGap, got.kg);
      check({tag, "_csdSym"}, csdSym, got.cs);
      check({tag, "_start_done"}, start, 1'b0);
      check({tag, "_weK_seen"}, wek_seen, exp_wek);
      if (got.f) begin
        check({tag, "_kmem"}, {kmem[0], kmem[1], kmem[2], kmem[3]}, exp_k);
        check({tag, "_regK"}, {regK[0], regK[1], regK[2], regK[3]}, exp_k);
      end
      @(posedge clk); #1;
      check({tag, "_done_fall"}, {done, busy}, 2'b00);
      for (int c = 0; c < 4; c++) begin
        if (done) dones++;
        @(posedge clk); #1;
      end
      check({tag, "_done_count"}, 32'(dones), 32'd1);
      check({tag, "_found_hold"}, found, got.f);
    end
  endtask

  exp_t ea, ef, ec;

  initial begin
    // Reset with a go pulse that must be ignored
    reset = 1'b1;
    go    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    go    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("reset_idle_outs", all_outs(), 20'd0);
      @(posedge clk); #1;
    end

    ea = '{lat: 51, f: 1'b1, kg: 1'b1, cs: 1'b1};
    ef = '{lat: 33, f: 1'b0, kg: 1'b0, cs: 1'b0};
    ec = '{lat: 63, f: 1'b1, kg: 1'b0, cs: 1'b1};

    // Hits at 2,5,7,9 with a stray go pulse while busy
    do_run("hits2579", 16'b0000_0010_1010_0100, ea, {4'd2, 4'd5, 4'd7, 4'd9}, 1'b1, 1'b1);
    // No hits: fail path clears the previous flags
    do_run("nohits", 16'h0000, ef, 16'h0000, 1'b0, 1'b0);
    // Hits at 0,1,2,15: the fourth hit lands on the last address
    do_run("hits0115", 16'b1000_0000_0000_0111, ec, {4'd0, 4'd1, 4'd2, 4'd15}, 1'b1, 1'b0);

    // Reset in the middle of the K reload phase
    load_csd(16'b0000_0010_1010_0100);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    check("midrun_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset_outs", all_outs(), 20'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_run("rerun2579", 16'b0000_0010_1010_0100, ea, {4'd2, 4'd5, 4'd7, 4'd9}, 1'b1, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
